// File: rtl/timer_pkg.sv
// Shared types and digit limits for the MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] SEC_UNITS_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
  localparam logic [3:0] MIN_UNITS_MAX = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0->WRAP and flags a borrow to the next digit.
module bcd_down_digit #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dec,
  input  logic       load_en,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] r_digit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_digit <= '0;
    end else if (load_en) begin
      r_digit <= load_val;
    end else if (dec) begin
      r_digit <= (r_digit == 4'd0) ? WRAP : r_digit - 4'd1;
    end
  end

  assign digit      = r_digit;
  assign borrow_out = dec & (r_digit == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: load/start/stop control FSM over a borrow-chained digit cascade.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned MAX_MIN_TENS = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  sec_units,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_units,
  output logic [3:0]  min_tens,
  output logic        running,
  output logic        done,
  output logic        expired,
  output logic        load_error
);

  localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN_TENS);

  state_t r_state;
  logic   r_done;
  logic   r_load_error;

  logic w_load_valid;
  logic w_load_en;
  logic w_dec;
  logic w_is_zero;
  logic w_is_one;
  logic w_borrow_su;
  logic w_borrow_st;
  logic w_borrow_mu;
  logic w_borrow_mt;

  assign w_load_valid = (load_value[3:0]   <= SEC_UNITS_MAX) &&
                        (load_value[7:4]   <= SEC_TENS_MAX)  &&
                        (load_value[11:8]  <= MIN_UNITS_MAX) &&
                        (load_value[15:12] <= MIN_TENS_MAX);
  assign w_load_en    = load & w_load_valid;

  // Tick only acts when no higher-priority control input is present this cycle.
  assign w_dec = tick & ~load & ~stop & ~start & (r_state == RUN);

  assign w_is_zero = ({min_tens, min_units, sec_tens, sec_units} == 16'h0000);
  assign w_is_one  = ({min_tens, min_units, sec_tens, sec_units} == 16'h0001);

  bcd_down_digit #(.WRAP(SEC_UNITS_MAX)) u_sec_units (
    .clock      (clock),
    .reset      (reset),
    .dec        (w_dec),
    .load_en    (w_load_en),
    .load_val   (load_value[3:0]),
    .digit      (sec_units),
    .borrow_out (w_borrow_su)
  );

  bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
    .clock      (clock),
    .reset      (reset),
    .dec        (w_borrow_su),
    .load_en    (w_load_en),
    .load_val   (load_value[7:4]),
    .digit      (sec_tens),
    .borrow_out (w_borrow_st)
  );

  bcd_down_digit #(.WRAP(MIN_UNITS_MAX)) u_min_units (
    .clock      (clock),
    .reset      (reset),
    .dec        (w_borrow_st),
    .load_en    (w_load_en),
    .load_val   (load_value[11:8]),
    .digit      (min_units),
    .borrow_out (w_borrow_mu)
  );

  // Never wraps in practice: RUN leaves at 00:00 before minutes-tens could underflow.
  bcd_down_digit #(.WRAP(MIN_TENS_MAX)) u_min_tens (
    .clock      (clock),
    .reset      (reset),
    .dec        (w_borrow_mu),
    .load_en    (w_load_en),
    .load_val   (load_value[15:12]),
    .digit      (min_tens),
    .borrow_out (w_borrow_mt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_done       <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_load_error <= 1'b0;
      if (load) begin
        if (w_load_valid) r_state      <= IDLE;
        else              r_load_error <= 1'b1;
      end else if (stop) begin
        if (r_state == RUN) r_state <= PAUSE;
      end else if (start) begin
        if ((r_state == IDLE && !w_is_zero) || r_state == PAUSE) r_state <= RUN;
      end else if (tick && r_state == RUN && w_is_one) begin
        r_state <= EXPIRED;
        r_done  <= 1'b1;
      end
    end
  end

  assign running    = (r_state == RUN);
  assign expired    = (r_state == EXPIRED);
  assign done       = r_done;
  assign load_error = r_load_error;

  logic w_unused;
  assign w_unused = w_borrow_mt;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  logic        clock;
  logic        reset;
  logic        tick;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        stop;
  logic [3:0]  sec_units;
  logic [3:0]  sec_tens;
  logic [3:0]  min_units;
  logic [3:0]  min_tens;
  logic        running;
  logic        done;
  logic        expired;
  logic        load_error;

  int unsigned checks;
  int unsigned errors;

  countdown_timer #(.MAX_MIN_TENS(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .sec_units  (sec_units),
    .sec_tens   (sec_tens),
    .min_units  (min_units),
    .min_tens   (min_tens),
    .running    (running),
    .done       (done),
    .expired    (expired),
    .load_error (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] digits();
    return {min_tens, min_units, sec_tens, sec_units};
  endfunction

  // {running, done, expired, load_error}
  function automatic logic [15:0] flags();
    return {12'h000, running, done, expired, load_error};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic l, input logic [15:0] lv, input logic sa,
                     input logic sp, input logic tk);
    load       = l;
    load_value = lv;
    start      = sa;
    stop       = sp;
    tick       = tk;
    @(posedge clock);
    #1;
    load       = 1'b0;
    load_value = 16'h0000;
    start      = 1'b0;
    stop       = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    tick       = 1'b0;
    load       = 1'b0;
    load_value = 16'h0000;
    start      = 1'b0;
    stop       = 1'b0;

    #12;
    chk("reset_digits", digits(), 16'h0000);
    chk("reset_flags",  flags(),  16'h0000);
    #10 reset = 1'b1;

    // Load 01:30, start, count down 90 ticks
    cyc(1'b1, 16'h0130, 1'b0, 1'b0, 1'b0);
    chk("load_0130",    digits(), 16'h0130);
    chk("load_idle",    flags(),  16'h0000);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("start_run",    flags(),  16'h0008);
    chk("start_digits", digits(), 16'h0130);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("first_tick",   digits(), 16'h0129);
    ticks(88);
    chk("at_0001",      digits(), 16'h0001);
    chk("at_0001_flag", flags(),  16'h0008);
    ticks(1);
    chk("expire_digits", digits(), 16'h0000);
    chk("expire_flags",  flags(),  16'h0006);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("done_one_cycle", flags(), 16'h0002);

    // EXPIRED ignores start/tick/stop
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("exp_start_tick", flags(),  16'h0002);
    chk("exp_hold_zero",  digits(), 16'h0000);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("exp_stop",       flags(),  16'h0002);

    // Borrow cascade
    cyc(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    chk("exp_load_idle",  flags(),  16'h0000);
    chk("exp_load_value", digits(), 16'h1000);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("cascade_0959",   digits(), 16'h0959);
    cyc(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("cascade_0059",   digits(), 16'h0059);

    // Pause behaviour
    cyc(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk("pause_pre",      digits(), 16'h0003);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("stop_tick_hold", digits(), 16'h0003);
    chk("stop_paused",    flags(),  16'h0000);
    ticks(3);
    chk("pause_ign_tick", digits(), 16'h0003);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("pause_stop_nop", flags(),  16'h0000);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("resume_run",     flags(),  16'h0008);
    chk("resume_no_dec",  digits(), 16'h0003);
    ticks(2);
    chk("pause_0001",     flags(),  16'h0008);
    ticks(1);
    chk("pause_done_dig", digits(), 16'h0000);
    chk("pause_done",     flags(),  16'h0006);

    // Invalid loads
    cyc(1'b1, 16'h0215, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0070, 1'b0, 1'b0, 1'b0);
    chk("bad_sectens_err", flags(),  16'h0009);
    chk("bad_sectens_dig", digits(), 16'h0215);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("err_one_cycle",   flags(),  16'h0008);
    cyc(1'b1, 16'h6000, 1'b0, 1'b0, 1'b0);
    chk("bad_mintens_err", flags(),  16'h0009);
    chk("bad_mintens_dig", digits(), 16'h0215);
    cyc(1'b1, 16'h5959, 1'b0, 1'b0, 1'b1);
    chk("max_load_flags",  flags(),  16'h0000);
    chk("max_load_dig",    digits(), 16'h5959);

    // Load beats tick in RUN
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0042, 1'b0, 1'b0, 1'b1);
    chk("load_tick_dig",   digits(), 16'h0042);
    chk("load_tick_idle",  flags(),  16'h0000);

    // Zero start
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("zero_start",      flags(),  16'h0000);

    // Mid-count asynchronous reset
    cyc(1'b1, 16'h0043, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("pre_reset_dig",   digits(), 16'h0042);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_dig",   digits(), 16'h0000);
    chk("async_rst_flags", flags(),  16'h0000);
    #2 reset = 1'b1;
    ticks(1);
    chk("post_rst_tick",   digits(), 16'h0000);
    chk("post_rst_flags",  flags(),  16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
